// File: rtl/fifo_burst_reader.sv
// Read-side burst drain engine: pops BURST_LEN words from a FIFO into a
// 2-entry valid/ready output buffer and pulses DONE once the burst is drained.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] BURST_LEN,
  output logic             BUSY,
  output logic             DONE,
  input  logic             FIFO_EMPTY,
  input  logic [WIDTH-1:0] FIFO_RD_DATA,
  output logic             FIFO_R_INC,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             done_n;
  logic [1:0]       count, count_n;
  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [2];
  logic             push, consume;

  // Pop depends only on registered state and FIFO_EMPTY, never on OUT_READY
  assign push       = (state == BURST) && !FIFO_EMPTY && (count < 2'd2);
  assign FIFO_R_INC = push;
  assign OUT_VALID  = (count != 2'd0);
  assign consume    = OUT_VALID && OUT_READY;
  assign OUT_DATA   = mem[rd_ptr];
  assign BUSY       = (state != IDLE);

  always_comb begin
    count_n = count;
    case ({push, consume})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  // Next-state logic; DRAIN completes on the edge that leaves the buffer empty
  always_comb begin
    state_n = state;
    rem_n   = rem;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          rem_n   = BURST_LEN;
          state_n = (BURST_LEN != '0) ? BURST : DRAIN;
        end
      end
      BURST: begin
        if (push) begin
          if (rem != '0) rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (count_n == 2'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rem   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      DONE  <= done_n;
    end
  end

  // Output buffer storage and pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count <= count_n;
      if (push) begin
        mem[wr_ptr] <= FIFO_RD_DATA;
        wr_ptr      <= ~wr_ptr;
      end
      if (consume) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a behavioural FIFO feeds the DUT,
// directed bursts queue expected words, a negedge monitor checks the output.
module tb_fifo_burst_reader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] BURST_LEN;
  logic       BUSY;
  logic       DONE;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_RD_DATA;
  logic       FIFO_R_INC;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;

  fifo_burst_reader #(.WIDTH(8), .LEN_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BURST_LEN(BURST_LEN),
    .BUSY(BUSY), .DONE(DONE), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_R_INC(FIFO_R_INC),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  // Behavioural FIFO read port: RD_DATA is the word at the head
  logic [7:0] fifo_mem [32];
  int         head = 0;
  int         tail = 0;
  logic       pop_next = 1'b0;
  assign FIFO_EMPTY   = (head == tail);
  assign FIFO_RD_DATA = fifo_mem[head[4:0]];

  always @(posedge CLK) begin
    #1;
    if (pop_next) head = head + 1;
  end

  int         checks = 0;
  int         passes = 0;
  int         pops = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q [$];
  logic       stall_prev = 1'b0;
  logic [7:0] held = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: scoreboard compare on every accepted word, plus hold stability
  always @(negedge CLK) begin
    logic [7:0] e;
    pop_next = FIFO_R_INC;
    if (FIFO_R_INC) pops++;
    if (DONE) done_cnt++;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL extra_word: got %02h, expected no word", OUT_DATA);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(OUT_DATA), 32'(e));
      end
    end
    if (stall_prev && OUT_VALID) check("hold_stable", 32'(OUT_DATA), 32'(held));
    stall_prev = OUT_VALID && !OUT_READY && !RST;
    held       = OUT_DATA;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] d);
    fifo_mem[tail[4:0]] = d;
    tail = tail + 1;
  endtask

  task automatic expect_word(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!DONE && k < 40) begin
      tick(1);
      k++;
    end
    check(name, 32'(DONE), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, d0;
    int first_pop, last_pop, npop, first_valid, done_i, nbusy;
    RST = 1'b1; START = 1'b0; BURST_LEN = 4'd0; OUT_READY = 1'b1;
    tick(2);
    RST = 1'b0;
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_data",  32'(OUT_DATA),  32'd0);
    check("rst_busy",  32'(BUSY),      32'd0);
    check("rst_done",  32'(DONE),      32'd0);
    check("rst_rinc",  32'(FIFO_R_INC), 32'd0);
    tick(1);

    // Full-rate burst of 5
    for (int i = 0; i < 5; i++) begin
      push_fifo(8'h11 + 8'(i));
      expect_word(8'h11 + 8'(i));
    end
    p0 = pops; d0 = done_cnt;
    START = 1'b1; BURST_LEN = 4'd5;
    tick(1);
    START = 1'b0;
    first_pop = -1; last_pop = -1; npop = 0; first_valid = -1; done_i = -1; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (FIFO_R_INC) begin
        npop++;
        last_pop = i;
        if (first_pop < 0) first_pop = i;
      end
      if (OUT_VALID && first_valid < 0) first_valid = i;
      if (BUSY) nbusy++;
      if (DONE) begin
        done_i = i;
        break;
      end
      tick(1);
    end
    check("t1_first_pop",   32'(first_pop),   32'd0);
    check("t1_last_pop",    32'(last_pop),    32'd4);
    check("t1_npop",        32'(npop),        32'd5);
    check("t1_first_valid", 32'(first_valid), 32'd1);
    check("t1_done_cycle",  32'(done_i),      32'd6);
    check("t1_busy_cycles", 32'(nbusy),       32'd6);
    tick(2);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_pops",      32'(pops - p0),     32'd5);

    // Backpressure: 6 stalled cycles allow only 2 pops
    for (int i = 0; i < 5; i++) begin
      push_fifo(8'h11 + 8'(i));
      expect_word(8'h11 + 8'(i));
    end
    p0 = pops; d0 = done_cnt;
    OUT_READY = 1'b0;
    START = 1'b1; BURST_LEN = 4'd5;
    tick(1);
    START = 1'b0;
    tick(5);
    check("t2_stall_pops",  32'(pops - p0), 32'd2);
    check("t2_stall_data",  32'(OUT_DATA),  32'h11);
    check("t2_stall_valid", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    wait_done("t2_done");
    tick(2);
    check("t2_pops",      32'(pops - p0),     32'd5);
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // FIFO runs empty mid-burst, refills later
    push_fifo(8'hA0);
    expect_word(8'hA0); expect_word(8'hA1); expect_word(8'hA2);
    p0 = pops; d0 = done_cnt;
    START = 1'b1; BURST_LEN = 4'd3;
    tick(1);
    START = 1'b0;
    tick(4);
    check("t3_empty_pops", 32'(pops - p0), 32'd1);
    check("t3_empty_busy", 32'(BUSY),      32'd1);
    push_fifo(8'hA1); push_fifo(8'hA2); push_fifo(8'hA3);
    wait_done("t3_done");
    tick(3);
    check("t3_pops",      32'(pops - p0),     32'd3);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // Zero-length burst with a word still in the FIFO
    p0 = pops; d0 = done_cnt;
    START = 1'b1; BURST_LEN = 4'd0;
    tick(1);
    START = 1'b0;
    check("t4_busy_k",  32'(BUSY),      32'd1);
    check("t4_done_k",  32'(DONE),      32'd0);
    check("t4_valid_k", 32'(OUT_VALID), 32'd0);
    tick(1);
    check("t4_done_k1",  32'(DONE),      32'd1);
    check("t4_busy_k1",  32'(BUSY),      32'd0);
    check("t4_valid_k1", 32'(OUT_VALID), 32'd0);
    tick(1);
    check("t4_pops", 32'(pops - p0), 32'd0);

    // Reset with one word buffered (A3) and rem=2
    p0 = pops;
    OUT_READY = 1'b0;
    START = 1'b1; BURST_LEN = 4'd3;
    tick(1);
    START = 1'b0;
    tick(1);
    check("t5_pre_valid", 32'(OUT_VALID), 32'd1);
    check("t5_pre_pops",  32'(pops - p0), 32'd1);
    d0 = done_cnt;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("t5_valid", 32'(OUT_VALID),  32'd0);
    check("t5_data",  32'(OUT_DATA),   32'd0);
    check("t5_busy",  32'(BUSY),       32'd0);
    check("t5_done",  32'(DONE),       32'd0);
    check("t5_rinc",  32'(FIFO_R_INC), 32'd0);
    tick(3);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    push_fifo(8'hC1);
    expect_word(8'hC1);
    OUT_READY = 1'b1;
    START = 1'b1; BURST_LEN = 4'd1;
    tick(1);
    START = 1'b0;
    wait_done("t5_after_done");
    tick(1);

    // START mid-burst ignored; START in DONE cycle accepted
    push_fifo(8'hD1); push_fifo(8'hD2); push_fifo(8'hD3); push_fifo(8'hE1);
    expect_word(8'hD1); expect_word(8'hD2); expect_word(8'hD3);
    p0 = pops; d0 = done_cnt;
    START = 1'b1; BURST_LEN = 4'd3;
    tick(1);
    START = 1'b0;
    tick(1);
    START = 1'b1; BURST_LEN = 4'd7;
    tick(1);
    START = 1'b0;
    wait_done("t6_done1");
    check("t6_pops1", 32'(pops - p0), 32'd3);
    expect_word(8'hE1);
    START = 1'b1; BURST_LEN = 4'd1;
    tick(1);
    START = 1'b0;
    check("t6_busy_rise", 32'(BUSY), 32'd1);
    wait_done("t6_done2");
    tick(2);
    check("t6_pops2",   32'(pops - p0),     32'd4);
    check("t6_done_n",  32'(done_cnt - d0), 32'd2);
    check("sb_drained", 32'(exp_q.size()),  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
